// File: rtl/hamming_scrub_pkg.sv
// Shared types and constants for the Hamming scrub scheduler.
package hamming_scrub_pkg;

    // Scrub FSM states: counting, parity-capture pause, syndrome check, write-back done
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PARK  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } scrub_state_t;

    // Fewest CHECK cycles the datapath needs for syndrome evaluation and correction
    localparam int unsigned CHECK_CYCLES_MIN = 3;

endpackage

// File: rtl/hamming_scrub_ctrl_chk.sv
// Checks for the scrub scheduler: legal CHECK length at elaboration and
// the datapath enable held low whenever a scrub is in progress.
module hamming_scrub_ctrl_chk
    import hamming_scrub_pkg::*;
#(
    parameter int unsigned CHECK_CYCLES = 3
) (
    input logic clk,
    input logic rst_n,
    input logic cnt_enable,
    input logic scrub_busy
);

    if (CHECK_CYCLES < CHECK_CYCLES_MIN) begin : g_check_cycles_too_small
        $error("hamming_scrub_ctrl: CHECK_CYCLES must be at least 3");
    end

    // The datapath must never advance while parity capture or correction is underway
    a_no_count_while_busy : assert property (
        @(posedge clk) disable iff (!rst_n) scrub_busy |-> !cnt_enable
    ) else $error("hamming_scrub_ctrl: cnt_enable high while scrub busy");

endmodule

// File: rtl/hamming_scrub_ctrl_sat_counter.sv
// Saturating up/down counter with synchronous clear.
// Clear wins over inc/dec; inc and dec together hold the value.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count register: clear first, then saturating increment or decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
        end else if (clr) begin
            count_r <= ZERO_C;
        end else if (inc && !dec && (count_r != MAX_C)) begin
            count_r <= count_r + ONE_C;
        end else if (dec && !inc && (count_r != ZERO_C)) begin
            count_r <= count_r - ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Scrub scheduler for the Hamming-protected counter datapath.
// Gates host count requests onto the datapath enable, forces a periodic or
// on-demand pause (PARK -> CHECK -> DONE) for parity capture, syndrome check
// and correction write-back, and counts detected error events.
// Optional feature: define HAMMING_SCRUB_BACKLOG_EN to replay count requests
// that stalled during a pause once the FSM is back in RUN.
module hamming_scrub_ctrl
    import hamming_scrub_pkg::*;
#(
    parameter int unsigned SCRUB_PERIOD_W = 16,
    parameter int unsigned CHECK_CYCLES   = 3,
    parameter int unsigned ERR_CNT_W      = 8,
    parameter int unsigned BACKLOG_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      count_req,
    input  logic [SCRUB_PERIOD_W-1:0] scrub_period,
    input  logic                      scrub_now,
    input  logic                      syn_nonzero,
    input  logic                      err_clr,
    output logic                      cnt_enable,
    output logic                      count_stall,
    output logic                      scrub_busy,
    output logic                      scrub_done,
    output logic                      err_event,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int unsigned TMR_W = $clog2(CHECK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD_C = TMR_W'(CHECK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO_C = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE_C  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [SCRUB_PERIOD_W-1:0] PER_ZERO_C = {SCRUB_PERIOD_W{1'b0}};
    localparam logic [SCRUB_PERIOD_W-1:0] PER_ONE_C  = {{(SCRUB_PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [BACKLOG_W-1:0] BKL_ZERO_C = {BACKLOG_W{1'b0}};

    scrub_state_t state_r;
    scrub_state_t next_state_s;

    logic [SCRUB_PERIOD_W-1:0] run_cnt_r;
    logic [TMR_W-1:0]          timer_r;
    logic                      err_flag_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      event_r;

    logic                      run_active_s;
    logic                      backlog_pend_s;
    logic                      cnt_enable_s;
    logic                      count_stall_s;
    logic                      trigger_s;
    logic                      err_inc_s;
    logic [BACKLOG_W-1:0]      backlog_s;
    logic [ERR_CNT_W-1:0]      err_count_s;

    // The FSM honours requests only in RUN and only while out of reset
    assign run_active_s   = rst_n && (state_r == RUN);
    assign backlog_pend_s = (backlog_s != BKL_ZERO_C);
    assign count_stall_s  = count_req && !run_active_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode, Mealy datapath enable and scrub trigger
    always_comb begin
        next_state_s = state_r;
        cnt_enable_s = 1'b0;
        trigger_s    = 1'b0;
        case (state_r)
            RUN: begin
                cnt_enable_s = run_active_s && (count_req || backlog_pend_s);
                if (scrub_now) begin
                    trigger_s = 1'b1;
                end else if ((scrub_period != PER_ZERO_C) && cnt_enable_s &&
                             (run_cnt_r >= (scrub_period - PER_ONE_C))) begin
                    trigger_s = 1'b1;
                end else begin
                    trigger_s = 1'b0;
                end
                if (trigger_s) begin
                    next_state_s = PARK;
                end else begin
                    next_state_s = RUN;
                end
            end
            PARK: begin
                next_state_s = CHECK;
            end
            CHECK: begin
                if (timer_r == TMR_ZERO_C) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CHECK;
                end
            end
            DONE: begin
                next_state_s = RUN;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // Run counter: counts enabled cycles, restarts on every scrub trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_r <= PER_ZERO_C;
        end else if (state_r == RUN) begin
            if (trigger_s) begin
                run_cnt_r <= PER_ZERO_C;
            end else if (cnt_enable_s) begin
                run_cnt_r <= run_cnt_r + PER_ONE_C;
            end else begin
                run_cnt_r <= run_cnt_r;
            end
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // CHECK timer: loaded in PARK, counts down to the DONE hand-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= TMR_ZERO_C;
        end else if (state_r == PARK) begin
            timer_r <= TMR_LOAD_C;
        end else if ((state_r == CHECK) && (timer_r != TMR_ZERO_C)) begin
            timer_r <= timer_r - TMR_ONE_C;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Error flag: any nonzero syndrome during CHECK, consumed in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_r <= 1'b0;
        end else if ((state_r == CHECK) && syn_nonzero) begin
            err_flag_r <= 1'b1;
        end else if (state_r == DONE) begin
            err_flag_r <= 1'b0;
        end else begin
            err_flag_r <= err_flag_r;
        end
    end

    // Status outputs registered from the next state so they align with the state itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            event_r <= 1'b0;
        end else begin
            busy_r  <= (next_state_s != RUN);
            done_r  <= (next_state_s == DONE);
            event_r <= (next_state_s == DONE) &&
                       (err_flag_r || ((state_r == CHECK) && syn_nonzero));
        end
    end

    assign err_inc_s = (state_r == DONE) && err_flag_r;

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_clr),
        .inc   (err_inc_s),
        .dec   (1'b0),
        .count (err_count_s)
    );

`ifdef HAMMING_SCRUB_BACKLOG_EN
    logic backlog_dec_s;

    // Replay only when the host is idle so the counter never advances twice in one cycle
    assign backlog_dec_s = run_active_s && backlog_pend_s && !count_req;

    sat_counter #(.W(BACKLOG_W)) u_backlog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (count_stall_s),
        .dec   (backlog_dec_s),
        .count (backlog_s)
    );
`else
    assign backlog_s = BKL_ZERO_C;
`endif

    hamming_scrub_ctrl_chk #(.CHECK_CYCLES(CHECK_CYCLES)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_enable (cnt_enable_s),
        .scrub_busy (busy_r)
    );

    assign cnt_enable  = cnt_enable_s;
    assign count_stall = count_stall_s;
    assign scrub_busy  = busy_r;
    assign scrub_done  = done_r;
    assign err_event   = event_r;
    assign err_count   = err_count_s;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl: each stimulus cycle queues its
// hand-computed expected outputs; a monitor on the falling edge pops and compares.
module tb_hamming_scrub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        count_req = 1'b0;
    logic [15:0] scrub_period = 16'd0;
    logic        scrub_now = 1'b0;
    logic        syn_nonzero = 1'b0;
    logic        err_clr = 1'b0;
    logic        cnt_enable;
    logic        count_stall;
    logic        scrub_busy;
    logic        scrub_done;
    logic        err_event;
    logic [7:0]  err_count;

    int total = 0;
    int bad = 0;

    logic [12:0] exp_q[$];
    string       name_q[$];
    logic [15:0] per_v = 16'd0;

    logic [12:0] mon_exp;
    logic [12:0] mon_got;
    string       mon_name;

`ifdef HAMMING_SCRUB_BACKLOG_EN
    localparam logic RP = 1'b1;
`else
    localparam logic RP = 1'b0;
`endif

    hamming_scrub_ctrl #(
        .SCRUB_PERIOD_W (16),
        .CHECK_CYCLES   (3),
        .ERR_CNT_W      (8),
        .BACKLOG_W      (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_req    (count_req),
        .scrub_period (scrub_period),
        .scrub_now    (scrub_now),
        .syn_nonzero  (syn_nonzero),
        .err_clr      (err_clr),
        .cnt_enable   (cnt_enable),
        .count_stall  (count_stall),
        .scrub_busy   (scrub_busy),
        .scrub_done   (scrub_done),
        .err_event    (err_event),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue its expected outputs
    task automatic cyc(input string nm, input logic rst, input logic req, input logic now,
                       input logic syn, input logic clr, input logic en, input logic st,
                       input logic bz, input logic dn, input logic ev, input logic [7:0] cnt);
        @(posedge clk);
        #1;
        rst_n        = ~rst;
        count_req    = req;
        scrub_now    = now;
        syn_nonzero  = syn;
        err_clr      = clr;
        scrub_period = per_v;
        exp_q.push_back({en, st, bz, dn, ev, cnt});
        name_q.push_back(nm);
    endtask

    // Monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {cnt_enable, count_stall, scrub_busy, scrub_done, err_event, err_count};
            total    = total + 1;
            if (mon_got !== mon_exp) begin
                bad = bad + 1;
                $display("FAIL %s: got en/st/bz/dn/ev/cnt=%b want %b", mon_name, mon_got, mon_exp);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;

        // reset: outputs zero, stall follows the request
        cyc("rst_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc("rst_req",  1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'd0);
        cyc("rel_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);

        // period 4, request held: 4 enabled, 5 forced low, done in the 5th
        per_v = 16'd4;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) cyc("per_run", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd0);
            cyc("per_park", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd0);
            for (int k = 0; k < 3; k++) cyc("per_check", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd0);
            cyc("per_done", 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 8'd0);
        end

        // request dropped: replay of saturated backlog only when compiled in
        per_v = 16'd0;
        for (int k = 0; k < 3; k++) cyc("replay", 0, 0, 0, 0, 0, RP, 0, 0, 0, 0, 8'd0);
        cyc("replay_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);

        // on-demand scrub with one syndrome hit in the first CHECK cycle
        cyc("err_trig",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc("err_park",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("err_chk_syn", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("err_chk",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("err_chk",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("err_done",    0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'd0);
        cyc("err_cnt1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd1);

        // hit in the last CHECK cycle, clear in DONE wins over the increment
        cyc("clr_trig",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1);
        cyc("clr_park",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd1);
        cyc("clr_chk",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd1);
        cyc("clr_chk",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd1);
        cyc("clr_chk_syn", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'd1);
        cyc("clr_done",    0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 8'd1);
        cyc("clr_zero",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);

        // syndrome outside CHECK ignored; scrub_now during CHECK ignored
        cyc("ign_run_syn",  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc("ign_trig",     0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc("ign_park_syn", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("ign_chk",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("ign_chk_now",  0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("ign_chk",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("ign_done",     0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'd0);
        for (int k = 0; k < 3; k++) cyc("ign_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);

        // lowering the period below the run count triggers on the next enabled cycle
        per_v = 16'd8;
        for (int k = 0; k < 5; k++) cyc("low_run", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd0);
        per_v = 16'd3;
        cyc("low_trig",    0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd0);
        cyc("low_park",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("low_chk_syn", 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("low_chk",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("low_chk",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("low_done",    0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'd0);
        cyc("low_run0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd1);

        // reset during CHECK returns everything to reset values at once
        per_v = 16'd0;
        cyc("rc_trig", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd1);
        cyc("rc_park", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd1);
        cyc("rc_chk",  0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'd1);
        cyc("rc_rst",  1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'd0);
        cyc("rc_rel",  0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd0);
        cyc("rc_run",  0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd0);
        cyc("rc_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
